sbox_ram_ctrl: RTL

//  Initiator side of the 16x4 S-box RAM interface: owns N_SBOX ram16x4bit

---
 rtl/sbox_ram_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/sbox_ram_ctrl.sv
// rtl/sbox_ram_ctrl.sv - initiator for N_SBOX 16x4 S-box RAMs: table load then one substitution per cycle
module sbox_ram_ctrl #(
    parameter int N_SBOX = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  RELOAD,
    input  logic                  LD_VALID,
    output logic                  LD_READY,
    input  logic [4*N_SBOX-1:0]   LD_DATA,
    output logic                  LOADED,
    input  logic                  SUB_VALID,
    output logic                  SUB_READY,
    input  logic [4*N_SBOX-1:0]   SUB_IN,
    output logic                  SUB_OUT_VALID,
    output logic [4*N_SBOX-1:0]   SUB_OUT,
    output logic [N_SBOX-1:0]     RAM_CEN,
    output logic [N_SBOX-1:0]     RAM_WEN,
    output logic [4*N_SBOX-1:0]   RAM_A,
    output logic [4*N_SBOX-1:0]   RAM_D,
    input  logic [4*N_SBOX-1:0]   RAM_Q
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          addr, addr_nxt;
    logic                rd_pending;
    logic [4*N_SBOX-1:0] sub_hold;
    logic                ld_acc, sub_acc;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= S_LOAD;
            addr       <= 4'd0;
            rd_pending <= 1'b0;
            sub_hold   <= '0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            rd_pending <= sub_acc;
            if (rd_pending)
                sub_hold <= RAM_Q;
        end
    end

    // RELOAD gates both readies so a colliding request is never accepted.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        LD_READY  = 1'b0;
        SUB_READY = 1'b0;
        ld_acc    = 1'b0;
        sub_acc   = 1'b0;
        case (state)
            S_LOAD: begin
                LD_READY = ~RELOAD;
                ld_acc   = LD_VALID & ~RELOAD;
                if (ld_acc) begin
                    addr_nxt = addr + 4'd1;
                    if (addr == 4'd15)
                        state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                SUB_READY = ~RELOAD;
                sub_acc   = SUB_VALID & ~RELOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
        if (RELOAD) begin
            state_nxt = S_LOAD;
            addr_nxt  = 4'd0;
        end
    end

    assign LOADED        = (state == S_RUN);
    assign RAM_CEN       = {N_SBOX{ld_acc | sub_acc}};
    assign RAM_WEN       = {N_SBOX{ld_acc}};
    assign RAM_A         = ld_acc ? {N_SBOX{addr}} : SUB_IN;
    assign RAM_D         = LD_DATA;
    assign SUB_OUT_VALID = rd_pending;
    // Read data is passed through on the pulse cycle and held afterwards.
    assign SUB_OUT       = rd_pending ? RAM_Q : sub_hold;

endmodule
